// File: rtl/d_cache_pkg.sv
// Shared definitions for the 2-way set-associative data cache.
package d_cache_pkg;

  typedef enum logic [2:0] {
    S_COMP,
    S_WB,
    S_GAP,
    S_ALLOC,
    S_REFILL
  } state_e;

  // Per-line metadata layout: {dirty, valid}
  localparam int unsigned META_W     = 2;
  localparam int unsigned META_VALID = 0;
  localparam int unsigned META_DIRTY = 1;

  // Upper bounds for the generic line/word helpers below
  localparam int unsigned LINE_MAX_W = 2048;
  localparam int unsigned WORD_MAX_W = 64;

  // Select word 'off' of a line made of word_w-bit words
  function automatic logic [WORD_MAX_W-1:0] word_sel(input logic [LINE_MAX_W-1:0] line,
                                                     input int unsigned off,
                                                     input int unsigned word_w);
    logic [LINE_MAX_W-1:0] sh;
    sh = line >> (off * word_w);
    return WORD_MAX_W'(sh);
  endfunction

  // Replace word 'off' of a line with 'word', leaving the other words intact
  function automatic logic [LINE_MAX_W-1:0] word_put(input logic [LINE_MAX_W-1:0] line,
                                                     input int unsigned off,
                                                     input int unsigned word_w,
                                                     input logic [WORD_MAX_W-1:0] word);
    logic [LINE_MAX_W-1:0] mask;
    mask = ((LINE_MAX_W'(1) << word_w) - LINE_MAX_W'(1)) << (off * word_w);
    return (line & ~mask) | ((LINE_MAX_W'(word) << (off * word_w)) & mask);
  endfunction

endpackage

// File: rtl/d_cache_way.sv
// One cache way: per-set valid/dirty metadata, tag and line data.
module d_cache_way
  import d_cache_pkg::*;
#(
  parameter int unsigned SETS       = 4,
  parameter int unsigned TAG_W      = 26,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                                clk,
  input  logic                                rst_i,
  input  logic [$clog2(SETS)-1:0]             set_i,
  input  logic [TAG_W-1:0]                    tag_i,
  output logic                                valid_o,
  output logic                                dirty_o,
  output logic [TAG_W-1:0]                    tag_o,
  output logic [LINE_WORDS*WORD_W-1:0]        line_o,
  output logic                                hit_o,
  input  logic                                wr_en_i,
  input  logic [$clog2(LINE_WORDS)-1:0]       wr_off_i,
  input  logic [WORD_W-1:0]                   wr_data_i,
  input  logic                                fill_en_i,
  input  logic [TAG_W-1:0]                    fill_tag_i,
  input  logic [LINE_WORDS*WORD_W-1:0]        fill_line_i
);

  localparam int unsigned LINE_W = LINE_WORDS * WORD_W;

  logic [META_W-1:0] meta_q [SETS];
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] data_q [SETS];

  // Combinational read of the addressed set and tag compare
  always_comb begin
    valid_o = meta_q[set_i][META_VALID];
    dirty_o = meta_q[set_i][META_DIRTY];
    tag_o   = tag_q[set_i];
    line_o  = data_q[set_i];
    hit_o   = meta_q[set_i][META_VALID] && (tag_q[set_i] == tag_i);
  end

  // Metadata: reset clears all lines; fill makes a clean valid line; store dirties it
  always_ff @(posedge clk) begin
    if (rst_i) begin
      for (int s = 0; s < int'(SETS); s++) begin
        meta_q[s] <= '0;
      end
    end else if (fill_en_i) begin
      meta_q[set_i][META_VALID] <= 1'b1;
      meta_q[set_i][META_DIRTY] <= 1'b0;
    end else if (wr_en_i) begin
      meta_q[set_i][META_DIRTY] <= 1'b1;
    end
  end

  // Tag and data storage: line fill or single-word store merge
  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[set_i]  <= fill_tag_i;
      data_q[set_i] <= fill_line_i;
    end else if (wr_en_i) begin
      data_q[set_i] <= LINE_W'(word_put(LINE_MAX_W'(data_q[set_i]), 32'(wr_off_i),
                                        WORD_W, WORD_MAX_W'(wr_data_i)));
    end
  end

endmodule

// File: rtl/d_cache_2way.sv
// 2-way set-associative write-back, write-allocate data cache with LRU and counters.
module d_cache_2way
  import d_cache_pkg::*;
#(
  parameter int unsigned ADDR_W     = 30,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned SETS       = 4
) (
  input  logic                                  clk,
  input  logic                                  proc_reset,
  input  logic                                  proc_read,
  input  logic                                  proc_write,
  input  logic [ADDR_W-1:0]                     proc_addr,
  input  logic [WORD_W-1:0]                     proc_wdata,
  output logic [WORD_W-1:0]                     proc_rdata,
  output logic                                  proc_stall,
  output logic                                  mem_read,
  output logic                                  mem_write,
  output logic [ADDR_W-$clog2(LINE_WORDS)-1:0]  mem_addr,
  output logic [LINE_WORDS*WORD_W-1:0]          mem_wdata,
  input  logic [LINE_WORDS*WORD_W-1:0]          mem_rdata,
  input  logic                                  mem_ready,
  output logic [31:0]                           hit_cnt,
  output logic [31:0]                           miss_cnt
);

  localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned LINE_W = LINE_WORDS * WORD_W;
  localparam int unsigned LADR_W = ADDR_W - OFF_W;

  state_e              state_q;
  logic [SETS-1:0]     lru_q;
  logic                victim_q;
  logic [LINE_W-1:0]   fill_q;
  logic                mem_read_q;
  logic                mem_write_q;
  logic [LADR_W-1:0]   mem_addr_q;
  logic [LINE_W-1:0]   mem_wdata_q;
  logic [31:0]         hit_cnt_q;
  logic [31:0]         miss_cnt_q;

  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    req_set;
  logic [OFF_W-1:0]    req_off;
  logic                req;

  logic [1:0]          way_hit;
  logic [1:0]          way_valid;
  logic [1:0]          way_dirty;
  logic [TAG_W-1:0]    way_tag  [2];
  logic [LINE_W-1:0]   way_line [2];

  logic                hit_c;
  logic                hit_way_c;
  logic                victim_c;
  logic                victim_dirty_c;

  assign req_tag = proc_addr[ADDR_W-1 -: TAG_W];
  assign req_set = proc_addr[OFF_W +: IDX_W];
  assign req_off = proc_addr[OFF_W-1:0];
  assign req     = proc_read | proc_write;

  for (genvar w = 0; w < 2; w++) begin : g_way
    d_cache_way #(
      .SETS       (SETS),
      .TAG_W      (TAG_W),
      .WORD_W     (WORD_W),
      .LINE_WORDS (LINE_WORDS)
    ) u_way (
      .clk         (clk),
      .rst_i       (proc_reset),
      .set_i       (req_set),
      .tag_i       (req_tag),
      .valid_o     (way_valid[w]),
      .dirty_o     (way_dirty[w]),
      .tag_o       (way_tag[w]),
      .line_o      (way_line[w]),
      .hit_o       (way_hit[w]),
      .wr_en_i     (!proc_reset && hit_c && proc_write && way_hit[w]),
      .wr_off_i    (req_off),
      .wr_data_i   (proc_wdata),
      .fill_en_i   (!proc_reset && (state_q == S_REFILL) && (victim_q == 1'(w))),
      .fill_tag_i  (req_tag),
      .fill_line_i (fill_q)
    );
  end

  // Hit detection, load data and victim choice for the addressed set
  always_comb begin
    hit_c          = req && (state_q == S_COMP) && (way_hit != 2'b00);
    hit_way_c      = way_hit[1];
    proc_rdata     = WORD_W'(word_sel(LINE_MAX_W'(way_line[hit_way_c]), 32'(req_off), WORD_W));
    if (!way_valid[0]) begin
      victim_c = 1'b0;
    end else if (!way_valid[1]) begin
      victim_c = 1'b1;
    end else begin
      victim_c = lru_q[req_set];
    end
    victim_dirty_c = way_valid[victim_c] && way_dirty[victim_c];
  end

  // Reset forces the processor and memory handshakes quiet immediately
  assign proc_stall = !proc_reset && req && !hit_c;
  assign mem_read   = !proc_reset && mem_read_q;
  assign mem_write  = !proc_reset && mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;

  // Controller: miss handling FSM, LRU update, memory request registers and counters
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q     <= S_COMP;
      lru_q       <= '0;
      victim_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        S_COMP: begin
          if (hit_c) begin
            lru_q[req_set] <= ~hit_way_c;
            if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
          end else if (req) begin
            victim_q <= victim_c;
            if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
            if (victim_dirty_c) begin
              state_q     <= S_WB;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {way_tag[victim_c], req_set};
              mem_wdata_q <= way_line[victim_c];
            end else begin
              state_q    <= S_ALLOC;
              mem_read_q <= 1'b1;
              mem_addr_q <= proc_addr[ADDR_W-1:OFF_W];
            end
          end
        end
        S_WB: begin
          if (mem_ready) begin
            state_q     <= S_GAP;
            mem_write_q <= 1'b0;
          end
        end
        S_GAP: begin
          state_q    <= S_ALLOC;
          mem_read_q <= 1'b1;
          mem_addr_q <= proc_addr[ADDR_W-1:OFF_W];
        end
        S_ALLOC: begin
          if (mem_ready) begin
            state_q    <= S_REFILL;
            mem_read_q <= 1'b0;
            fill_q     <= mem_rdata;
          end
        end
        S_REFILL: begin
          state_q        <= S_COMP;
          lru_q[req_set] <= ~victim_q;
        end
        default: begin
          state_q     <= S_COMP;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_d_cache_2way.sv
// Directed bench for d_cache_2way at default parameters.
module tb_d_cache_2way;

  logic         clk = 1'b0;
  logic         proc_reset;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;

  int checks = 0;
  int fails  = 0;

  d_cache_2way dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  always #5 clk = ~clk;

  // Fill line whose word i holds base+i
  function automatic logic [127:0] mk_line(input logic [31:0] base);
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  task automatic do_reset();
    proc_reset = 1'b1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    mem_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    proc_reset = 1'b0;
  endtask

  // Issue one access, act as a 1-cycle memory until the access completes
  task automatic access(input logic [29:0] addr, input logic wr, input logic [31:0] wdata,
                        input logic [127:0] fill, output int stalls, output logic saw_wb,
                        output logic gap_ok, output logic [27:0] wb_addr,
                        output logic [127:0] wb_data, output logic [27:0] rd_addr,
                        output logic [31:0] rdata);
    logic done;
    logic after_wb;
    stalls = 0; saw_wb = 1'b0; gap_ok = 1'b0; wb_addr = '0; wb_data = '0;
    rd_addr = '0; rdata = '0; done = 1'b0; after_wb = 1'b0;
    proc_addr = addr; proc_read = !wr; proc_write = wr; proc_wdata = wdata;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (!proc_stall) begin
        rdata = proc_rdata;
        done  = 1'b1;
        @(negedge clk);
      end else begin
        stalls++;
        if (after_wb) gap_ok = !mem_read && !mem_write;
        after_wb = 1'b0;
        if (mem_write) begin
          saw_wb = 1'b1; wb_addr = mem_addr; wb_data = mem_wdata;
          mem_ready = 1'b1; after_wb = 1'b1;
        end else if (mem_read) begin
          rd_addr = mem_addr; mem_rdata = fill; mem_ready = 1'b1;
        end
        @(negedge clk);
        mem_ready = 1'b0;
      end
    end
    proc_read = 1'b0; proc_write = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL access_timeout addr=%h: completed=%0b required 1", addr, done);
    end
  endtask

  task automatic test_reset();
    proc_reset = 1'b1; proc_read = 1'b1; proc_addr = 30'h10; mem_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (mem_read !== 1'b0) begin fails++; $display("FAIL rst_mem_read: got %b required 0", mem_read); end
    checks++; if (mem_write !== 1'b0) begin fails++; $display("FAIL rst_mem_write: got %b required 0", mem_write); end
    checks++; if (proc_stall !== 1'b0) begin fails++; $display("FAIL rst_stall: got %b required 0", proc_stall); end
    checks++; if (hit_cnt !== 32'd0) begin fails++; $display("FAIL rst_hit_cnt: got %0d required 0", hit_cnt); end
    checks++; if (miss_cnt !== 32'd0) begin fails++; $display("FAIL rst_miss_cnt: got %0d required 0", miss_cnt); end
    proc_read = 1'b0; proc_reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_miss();
    do_reset();
    proc_addr = 30'h10; proc_read = 1'b1;
    #1;
    checks++; if (proc_stall !== 1'b1) begin fails++; $display("FAIL rm_stall_comp: got %b required 1", proc_stall); end
    checks++; if (mem_read !== 1'b0) begin fails++; $display("FAIL rm_read_comp: got %b required 0", mem_read); end
    @(negedge clk);
    checks++; if (mem_read !== 1'b1) begin fails++; $display("FAIL rm_mem_read: got %b required 1", mem_read); end
    checks++; if (mem_addr !== 28'h4) begin fails++; $display("FAIL rm_mem_addr: got %h required 4", mem_addr); end
    checks++; if (miss_cnt !== 32'd1) begin fails++; $display("FAIL rm_miss_cnt: got %0d required 1", miss_cnt); end
    mem_rdata = {32'h3, 32'h2, 32'h1, 32'hA5A5A5A5}; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    checks++; if (mem_read !== 1'b0) begin fails++; $display("FAIL rm_refill_read: got %b required 0", mem_read); end
    checks++; if (proc_stall !== 1'b1) begin fails++; $display("FAIL rm_refill_stall: got %b required 1", proc_stall); end
    @(negedge clk);
    checks++; if (proc_stall !== 1'b0) begin fails++; $display("FAIL rm_hit_stall: got %b required 0", proc_stall); end
    checks++; if (proc_rdata !== 32'hA5A5A5A5) begin fails++; $display("FAIL rm_rdata: got %h required a5a5a5a5", proc_rdata); end
    @(negedge clk);
    proc_read = 1'b0;
    checks++; if (hit_cnt !== 32'd1) begin fails++; $display("FAIL rm_hit_cnt: got %0d required 1", hit_cnt); end
    checks++; if (miss_cnt !== 32'd1) begin fails++; $display("FAIL rm_miss_cnt_end: got %0d required 1", miss_cnt); end
  endtask

  task automatic test_two_ways();
    int st; logic wb, gp; logic [27:0] wa, ra; logic [127:0] wd; logic [31:0] rd;
    do_reset();
    access(30'h10, 1'b0, 32'h0, mk_line(32'h100), st, wb, gp, wa, wd, ra, rd);
    checks++; if (st !== 3 || wb !== 1'b0) begin fails++; $display("FAIL tw_fill0: stalls=%0d wb=%b required 3,0", st, wb); end
    access(30'h30, 1'b0, 32'h0, mk_line(32'h300), st, wb, gp, wa, wd, ra, rd);
    checks++; if (st !== 3 || wb !== 1'b0 || ra !== 28'hC) begin fails++; $display("FAIL tw_fill1: stalls=%0d wb=%b addr=%h required 3,0,c", st, wb, ra); end
    access(30'h10, 1'b0, 32'h0, '0, st, wb, gp, wa, wd, ra, rd);
    checks++; if (st !== 0 || rd !== 32'h100) begin fails++; $display("FAIL tw_rehit0: stalls=%0d data=%h required 0,100", st, rd); end
    access(30'h32, 1'b0, 32'h0, '0, st, wb, gp, wa, wd, ra, rd);
    checks++; if (st !== 0 || rd !== 32'h302) begin fails++; $display("FAIL tw_rehit1: stalls=%0d data=%h required 0,302", st, rd); end
    checks++; if (hit_cnt !== 32'd4 || miss_cnt !== 32'd2) begin fails++; $display("FAIL tw_counts: hit=%0d miss=%0d required 4,2", hit_cnt, miss_cnt); end
  endtask

  task automatic test_writeback();
    int st; logic wb, gp; logic [27:0] wa, ra; logic [127:0] wd; logic [31:0] rd;
    do_reset();
    access(30'h10, 1'b1, 32'hDEADBEEF, mk_line(32'h100), st, wb, gp, wa, wd, ra, rd);
    checks++; if (st !== 3) begin fails++; $display("FAIL wb_write_miss: stalls=%0d required 3", st); end
    access(30'h30, 1'b0, 32'h0, mk_line(32'h300), st, wb, gp, wa, wd, ra, rd);
    access(30'h50, 1'b0, 32'h0, mk_line(32'h500), st, wb, gp, wa, wd, ra, rd);
    checks++; if (wb !== 1'b1 || wa !== 28'h4) begin fails++; $display("FAIL wb_evict: wb=%b addr=%h required 1,4", wb, wa); end
    checks++; if (wd[31:0] !== 32'hDEADBEEF || wd[63:32] !== 32'h101) begin fails++; $display("FAIL wb_data: w0=%h w1=%h required deadbeef,101", wd[31:0], wd[63:32]); end
    checks++; if (gp !== 1'b1) begin fails++; $display("FAIL wb_gap: got %b required 1", gp); end
    checks++; if (ra !== 28'h14 || st !== 5 || rd !== 32'h500) begin fails++; $display("FAIL wb_refill: addr=%h stalls=%0d data=%h required 14,5,500", ra, st, rd); end
    access(30'h30, 1'b0, 32'h0, '0, st, wb, gp, wa, wd, ra, rd);
    checks++; if (st !== 0 || rd !== 32'h300) begin fails++; $display("FAIL wb_keep_other: stalls=%0d data=%h required 0,300", st, rd); end
  endtask

  task automatic test_write_miss();
    int st; logic wb, gp; logic [27:0] wa, ra; logic [127:0] wd; logic [31:0] rd;
    do_reset();
    access(30'h11, 1'b1, 32'h12345678, mk_line(32'h700), st, wb, gp, wa, wd, ra, rd);
    checks++; if (st !== 3 || wb !== 1'b0) begin fails++; $display("FAIL wm_fill: stalls=%0d wb=%b required 3,0", st, wb); end
    access(30'h11, 1'b0, 32'h0, '0, st, wb, gp, wa, wd, ra, rd);
    checks++; if (st !== 0 || rd !== 32'h12345678) begin fails++; $display("FAIL wm_merged: stalls=%0d data=%h required 0,12345678", st, rd); end
    access(30'h10, 1'b0, 32'h0, '0, st, wb, gp, wa, wd, ra, rd);
    checks++; if (rd !== 32'h700) begin fails++; $display("FAIL wm_neighbour: got %h required 700", rd); end
    access(30'h30, 1'b0, 32'h0, mk_line(32'h300), st, wb, gp, wa, wd, ra, rd);
    access(30'h50, 1'b0, 32'h0, mk_line(32'h500), st, wb, gp, wa, wd, ra, rd);
    checks++; if (wb !== 1'b1 || wa !== 28'h4 || wd[63:32] !== 32'h12345678 || wd[31:0] !== 32'h700) begin
      fails++; $display("FAIL wm_evict_dirty: wb=%b addr=%h w1=%h w0=%h required 1,4,12345678,700", wb, wa, wd[63:32], wd[31:0]);
    end
  endtask

  task automatic test_reset_mid();
    int st; logic wb, gp; logic [27:0] wa, ra; logic [127:0] wd; logic [31:0] rd;
    do_reset();
    proc_addr = 30'h10; proc_read = 1'b1;
    @(negedge clk);
    checks++; if (mem_read !== 1'b1) begin fails++; $display("FAIL rmid_alloc: got %b required 1", mem_read); end
    proc_reset = 1'b1;
    @(negedge clk);
    checks++; if (mem_read !== 1'b0 || proc_stall !== 1'b0) begin fails++; $display("FAIL rmid_drop: read=%b stall=%b required 0,0", mem_read, proc_stall); end
    proc_reset = 1'b0;
    #1;
    checks++; if (proc_stall !== 1'b1 || mem_read !== 1'b0 || miss_cnt !== 32'd0) begin
      fails++; $display("FAIL rmid_comp: stall=%b read=%b miss=%0d required 1,0,0", proc_stall, mem_read, miss_cnt);
    end
    access(30'h10, 1'b0, 32'h0, mk_line(32'h900), st, wb, gp, wa, wd, ra, rd);
    checks++; if (st !== 3 || rd !== 32'h900 || miss_cnt !== 32'd1) begin
      fails++; $display("FAIL rmid_remiss: stalls=%0d data=%h miss=%0d required 3,900,1", st, rd, miss_cnt);
    end
  endtask

  task automatic test_ready_idle();
    int st; logic wb, gp; logic [27:0] wa, ra; logic [127:0] wd; logic [31:0] rd;
    do_reset();
    access(30'h10, 1'b0, 32'h0, mk_line(32'h100), st, wb, gp, wa, wd, ra, rd);
    mem_ready = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || proc_stall !== 1'b0) begin
      fails++; $display("FAIL idle_quiet: read=%b write=%b stall=%b required 0,0,0", mem_read, mem_write, proc_stall);
    end
    checks++; if (hit_cnt !== 32'd1 || miss_cnt !== 32'd1) begin fails++; $display("FAIL idle_counts: hit=%0d miss=%0d required 1,1", hit_cnt, miss_cnt); end
    mem_ready = 1'b0;
    access(30'h10, 1'b0, 32'h0, '0, st, wb, gp, wa, wd, ra, rd);
    checks++; if (st !== 0 || rd !== 32'h100 || hit_cnt !== 32'd2) begin
      fails++; $display("FAIL idle_hit_after: stalls=%0d data=%h hit=%0d required 0,100,2", st, rd, hit_cnt);
    end
  endtask

  initial begin
    proc_reset = 1'b1; proc_read = 1'b0; proc_write = 1'b0;
    proc_addr = '0; proc_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_read_miss();
    test_two_ways();
    test_writeback();
    test_write_miss();
    test_reset_mid();
    test_ready_idle();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
